wb_regfile: RTL and testbench
=============================

Name: wb_regfile

Overview:
- Writeback-stage consumer of the MEM/WB pipeline register.
- Selects memory or ALU result, extracts and extends sub-word loads, and commits the result into a 32-entry general register file.
- Provides two combinational read ports to the decode stage, with same-cycle write-through bypass.
- Emits a registered commit trace, one cycle after each write, for debug and verification.

Parameters:
- DATA_W, 32, register and datapath width.
- REG_ADDR_W, 5, register index width; register count is 2**REG_ADDR_W.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- wb_valid  input  1  MEM/WB slot holds a real instruction; 0 means bubble.
- wb_reg_write  input  1  instruction writes a register.
- wb_mem_to_reg  input  1  1 = select MemData path, 0 = select ALUData path.
- wb_load_size  input  2  00 byte, 01 half, 10 word, 11 treated as word.
- wb_load_unsigned  input  1  1 = zero-extend sub-word load, 0 = sign-extend.
- MemDataIn  input  DATA_W  raw aligned memory word from MEM/WB.
- ALUDataIn  input  DATA_W  ALU result from MEM/WB; bits [1:0] are the load byte offset.
- WriteBackRegIn  input  REG_ADDR_W  destination register index.
- rd_addr_a  input  REG_ADDR_W  read port A index.
- rd_addr_b  input  REG_ADDR_W  read port B index.
- rd_data_a  output  DATA_W  read port A data (combinational).
- rd_data_b  output  DATA_W  read port B data (combinational).
- commit_valid  output  1  a register write happened in the previous cycle.
- commit_reg  output  REG_ADDR_W  index written in the previous cycle.
- commit_data  output  DATA_W  value written in the previous cycle.

Behaviour:
- Write enable: we = wb_valid & wb_reg_write & (WriteBackRegIn != 0).
- Result when wb_mem_to_reg = 0: ALUDataIn.
- Result when wb_mem_to_reg = 1: data extracted from MemDataIn, big-endian, off = ALUDataIn[1:0].
  - byte: off 0 -> [31:24], 1 -> [23:16], 2 -> [15:8], 3 -> [7:0].
  - half: off[1] = 0 -> [31:16], 1 -> [15:0]; off[0] is ignored.
  - word (10 or 11): full word; off is ignored.
  - Sub-word values are extended to DATA_W, sign or zero per wb_load_unsigned.
- Register write: on the rising edge with we = 1, regs[WriteBackRegIn] <= result. Single-cycle latency from MEM/WB outputs to regfile.
- Register 0: always reads 0; writes to it are discarded and produce no commit.
- Read ports:
  - rd_data_x = 0 if rd_addr_x == 0.
  - Otherwise rd_data_x = result if we = 1 and rd_addr_x == WriteBackRegIn (write-through bypass).
  - Otherwise rd_data_x = regs[rd_addr_x].
  - Both ports are independent; both may hit the bypass in the same cycle.
- Commit trace: registered every cycle.
  - commit_valid <= we.
  - commit_reg and commit_data load only when we = 1; otherwise they hold their previous values.
- Bubbles: wb_valid = 0 suppresses the write regardless of the other inputs.
- Reset (synchronous):
  - All regs cleared to 0.
  - commit_valid, commit_reg and commit_data cleared to 0.
  - A write presented in the same cycle as reset is dropped; reset wins.
  - The bypass is suppressed while reset = 1, so read ports return 0 during reset.
- Back-to-back writes to the same register: the later write wins; the commit trace shows each write in order.
- No stall input: every cycle consumes the current MEM/WB contents.

Test Plan:
- Reset, then read all 32 indices -> every rd_data = 0 and commit_valid = 0.
- ALU write: wb_valid = 1, wb_reg_write = 1, wb_mem_to_reg = 0, WriteBackRegIn = 5, ALUDataIn = 0x12345678, with rd_addr_a = 5 -> rd_data_a = 0x12345678 the same cycle (bypass). Next cycle: rd_data_a = 0x12345678 from storage, commit_valid = 1, commit_reg = 5, commit_data = 0x12345678.
- Loads, MemDataIn = 0x80FF7F01:
  - lb, off 0, signed -> 0xFFFFFF80.
  - lbu, off 0 -> 0x00000080.
  - lb, off 2 -> 0x0000007F.
  - lh, off 0 -> 0xFFFF80FF.
  - lhu, off 2 -> 0x00007F01.
  - lw, off 3 -> 0x80FF7F01.
- Write to $0 with ALUDataIn = 0xDEADBEEF -> rd_data_b at index 0 reads 0 in the same and the next cycle; commit_valid = 0.
- Bubble (wb_valid = 0, wb_reg_write = 1, WriteBackRegIn = 7) -> r7 is unchanged and commit_valid = 0. Then write r7 = 1 and r7 = 2 on consecutive cycles -> r7 reads 2, and the commit trace shows 1 then 2.
- Reset asserted in the same cycle as a write of 0xAAAA5555 to r9 -> r9 reads 0 after reset and commit_valid = 0.

Source files
------------

// File: rtl/wb_regfile_if.sv
// wb_regfile_if: MEM/WB-to-writeback bus.
//   Inputs to the regfile : MEM/WB slot (valid, control, data, destination)
//                           and the two decode-stage read indices.
//   Outputs of the regfile: the two read-port data words and the
//                           registered commit trace.
// Modports: master = pipeline / decode side, slave = wb_regfile.
interface wb_regfile_if #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5
);
  logic                  wb_valid;
  logic                  wb_reg_write;
  logic                  wb_mem_to_reg;
  logic [1:0]            wb_load_size;
  logic                  wb_load_unsigned;
  logic [DATA_W-1:0]     MemDataIn;
  logic [DATA_W-1:0]     ALUDataIn;
  logic [REG_ADDR_W-1:0] WriteBackRegIn;
  logic [REG_ADDR_W-1:0] rd_addr_a;
  logic [REG_ADDR_W-1:0] rd_addr_b;
  logic [DATA_W-1:0]     rd_data_a;
  logic [DATA_W-1:0]     rd_data_b;
  logic                  commit_valid;
  logic [REG_ADDR_W-1:0] commit_reg;
  logic [DATA_W-1:0]     commit_data;

  modport slave (
    input  wb_valid, wb_reg_write, wb_mem_to_reg, wb_load_size, wb_load_unsigned,
    input  MemDataIn, ALUDataIn, WriteBackRegIn, rd_addr_a, rd_addr_b,
    output rd_data_a, rd_data_b, commit_valid, commit_reg, commit_data
  );

  modport master (
    output wb_valid, wb_reg_write, wb_mem_to_reg, wb_load_size, wb_load_unsigned,
    output MemDataIn, ALUDataIn, WriteBackRegIn, rd_addr_a, rd_addr_b,
    input  rd_data_a, rd_data_b, commit_valid, commit_reg, commit_data
  );
endinterface

// File: rtl/wb_regfile.sv
// wb_regfile: writeback stage and 2**REG_ADDR_W-entry general register file.
//   clk   : rising-edge clock.
//   reset : synchronous, active-high; clears registers and commit trace.
//   bus   : wb_regfile_if.slave -- MEM/WB slot in, two combinational read
//           ports (with same-cycle write-through bypass) and a registered
//           commit trace out.
// Loads are big-endian: byte offset 0 is the most significant byte.
// The sub-word extraction assumes DATA_W = 32.
module wb_regfile #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic         clk,
  input  logic         reset,
  wb_regfile_if.slave  bus
);
  localparam int NREGS = 2 ** REG_ADDR_W;

  logic                  we;
  logic [1:0]            off;
  logic [7:0]            byte_sel;
  logic [15:0]           half_sel;
  logic [DATA_W-1:0]     mem_ext;
  logic [DATA_W-1:0]     result;
  logic [DATA_W-1:0]     regs [NREGS];

  logic                  commit_valid_reg;
  logic [REG_ADDR_W-1:0] commit_reg_reg;
  logic [DATA_W-1:0]     commit_data_reg;

  // Writes to register 0 are discarded and leave no commit record.
  assign we = bus.wb_valid & bus.wb_reg_write & (bus.WriteBackRegIn != '0);

  always_comb begin
    off      = bus.ALUDataIn[1:0];
    byte_sel = 8'h00;
    half_sel = 16'h0000;
    mem_ext  = '0;

    case (off)
      2'd0:    byte_sel = bus.MemDataIn[31:24];
      2'd1:    byte_sel = bus.MemDataIn[23:16];
      2'd2:    byte_sel = bus.MemDataIn[15:8];
      default: byte_sel = bus.MemDataIn[7:0];
    endcase

    // Half-word loads only look at off[1]; off[0] is ignored.
    half_sel = off[1] ? bus.MemDataIn[15:0] : bus.MemDataIn[31:16];

    case (bus.wb_load_size)
      2'b00: mem_ext = bus.wb_load_unsigned ? {{(DATA_W-8){1'b0}}, byte_sel}
                                            : {{(DATA_W-8){byte_sel[7]}}, byte_sel};
      2'b01: mem_ext = bus.wb_load_unsigned ? {{(DATA_W-16){1'b0}}, half_sel}
                                            : {{(DATA_W-16){half_sel[15]}}, half_sel};
      default: mem_ext = bus.MemDataIn;   // 10 and 11 are both full-word loads
    endcase

    result = bus.wb_mem_to_reg ? mem_ext : bus.ALUDataIn;
  end

  // Register storage. Entry 0 is never written (we excludes it) and the
  // read ports force it to zero, so it only exists to keep indexing simple.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (we) begin
      regs[bus.WriteBackRegIn] <= result;
    end
  end

  // Read ports: zero index and reset both read as zero; a matching write in
  // the current cycle is forwarded so decode sees it without a stall.
  logic [REG_ADDR_W-1:0] rd_addr [2];
  logic [DATA_W-1:0]     rd_data [2];

  assign rd_addr[0] = bus.rd_addr_a;
  assign rd_addr[1] = bus.rd_addr_b;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : gen_rd_port
      assign rd_data[gi] = (reset || rd_addr[gi] == '0)             ? '0 :
                           (we && rd_addr[gi] == bus.WriteBackRegIn) ? result :
                                                                       regs[rd_addr[gi]];
    end
  endgenerate

  assign bus.rd_data_a = rd_data[0];
  assign bus.rd_data_b = rd_data[1];

  // Commit trace: valid pulses for one cycle after each write; index and
  // data hold the most recent write until the next one.
  always_ff @(posedge clk) begin
    if (reset) begin
      commit_valid_reg <= 1'b0;
      commit_reg_reg   <= '0;
      commit_data_reg  <= '0;
    end else begin
      commit_valid_reg <= we;
      if (we) begin
        commit_reg_reg  <= bus.WriteBackRegIn;
        commit_data_reg <= result;
      end
    end
  end

  assign bus.commit_valid = commit_valid_reg;
  assign bus.commit_reg   = commit_reg_reg;
  assign bus.commit_data  = commit_data_reg;
endmodule

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile: directed bench for wb_regfile. A table of writeback
// vectors (ALU and load extraction cases) is applied in a loop, followed by
// hand-written sequences for reset, register 0, bubbles, back-to-back
// writes, dual-port bypass and reset-versus-write.
module tb_wb_regfile;
  logic clk = 1'b0;
  logic reset;

  wb_regfile_if #(.DATA_W(32), .REG_ADDR_W(5)) bus ();

  wb_regfile #(.DATA_W(32), .REG_ADDR_W(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic        mtr;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] mem;
    logic [31:0] alu;
    logic [4:0]  rd;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.wb_valid         = 1'b0;
    bus.wb_reg_write     = 1'b0;
    bus.wb_mem_to_reg    = 1'b0;
    bus.wb_load_size     = 2'b10;
    bus.wb_load_unsigned = 1'b0;
    bus.MemDataIn        = 32'h0;
    bus.ALUDataIn        = 32'h0;
    bus.WriteBackRegIn   = 5'd0;
  endtask

  task automatic drive(input logic valid, input logic [4:0] rd, input logic mtr,
                       input logic [1:0] size, input logic uns,
                       input logic [31:0] mem, input logic [31:0] alu);
    bus.wb_valid         = valid;
    bus.wb_reg_write     = 1'b1;
    bus.wb_mem_to_reg    = mtr;
    bus.wb_load_size     = size;
    bus.wb_load_unsigned = uns;
    bus.MemDataIn        = mem;
    bus.ALUDataIn        = alu;
    bus.WriteBackRegIn   = rd;
  endtask

  initial begin
    //            mtr   size   uns   mem            alu            rd     expected
    vecs[0]  = '{1'b0, 2'b10, 1'b0, 32'h80FF7F01, 32'h12345678, 5'd5,  32'h12345678}; // ALU
    vecs[1]  = '{1'b1, 2'b00, 1'b0, 32'h80FF7F01, 32'h00001000, 5'd10, 32'hFFFFFF80}; // lb  off0
    vecs[2]  = '{1'b1, 2'b00, 1'b1, 32'h80FF7F01, 32'h00001000, 5'd11, 32'h00000080}; // lbu off0
    vecs[3]  = '{1'b1, 2'b00, 1'b0, 32'h80FF7F01, 32'h00001002, 5'd12, 32'h0000007F}; // lb  off2
    vecs[4]  = '{1'b1, 2'b01, 1'b0, 32'h80FF7F01, 32'h00001000, 5'd13, 32'hFFFF80FF}; // lh  off0
    vecs[5]  = '{1'b1, 2'b01, 1'b1, 32'h80FF7F01, 32'h00001002, 5'd14, 32'h00007F01}; // lhu off2
    vecs[6]  = '{1'b1, 2'b10, 1'b0, 32'h80FF7F01, 32'h00001003, 5'd15, 32'h80FF7F01}; // lw  off3
    vecs[7]  = '{1'b1, 2'b00, 1'b0, 32'h80FF7F01, 32'h00001001, 5'd16, 32'hFFFFFFFF}; // lb  off1
    vecs[8]  = '{1'b1, 2'b00, 1'b1, 32'h80FF7F01, 32'h00001003, 5'd17, 32'h00000001}; // lbu off3
    vecs[9]  = '{1'b1, 2'b01, 1'b0, 32'h80FF7F01, 32'h00001003, 5'd18, 32'h00007F01}; // lh  off3
    vecs[10] = '{1'b1, 2'b11, 1'b0, 32'h80FF7F01, 32'h00001001, 5'd19, 32'h80FF7F01}; // size11
    vecs[11] = '{1'b1, 2'b01, 1'b1, 32'h80FF7F01, 32'h00001001, 5'd20, 32'h000080FF}; // lhu off1
    vecs[12] = '{1'b0, 2'b00, 1'b0, 32'h80FF7F01, 32'h00000081, 5'd21, 32'h00000081}; // ALU, size ignored

    // ---------------- reset, then read every index ----------------
    reset = 1'b1;
    idle();
    bus.rd_addr_a = 5'd0;
    bus.rd_addr_b = 5'd0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    chk("reset_commit_valid", {31'b0, bus.commit_valid}, 32'h0);
    for (int i = 0; i < 32; i++) begin
      bus.rd_addr_a = 5'(i);
      bus.rd_addr_b = 5'(31 - i);
      #1;
      chk($sformatf("reset_rd_a[%0d]", i), bus.rd_data_a, 32'h0);
      chk($sformatf("reset_rd_b[%0d]", 31 - i), bus.rd_data_b, 32'h0);
      tick();
    end
    $display("[TB] reset sequence: 32 indices read");

    // ---------------- vector table ----------------
    for (int v = 0; v < 13; v++) begin
      drive(1'b1, vecs[v].rd, vecs[v].mtr, vecs[v].size, vecs[v].uns, vecs[v].mem, vecs[v].alu);
      bus.rd_addr_a = vecs[v].rd;
      #1;
      chk($sformatf("vec%0d_bypass", v), bus.rd_data_a, vecs[v].exp);
      tick();
      idle();
      #1;
      chk($sformatf("vec%0d_commit_valid", v), {31'b0, bus.commit_valid}, 32'h1);
      chk($sformatf("vec%0d_commit_reg", v), {27'b0, bus.commit_reg}, {27'b0, vecs[v].rd});
      chk($sformatf("vec%0d_commit_data", v), bus.commit_data, vecs[v].exp);
      chk($sformatf("vec%0d_stored", v), bus.rd_data_a, vecs[v].exp);
      tick();
      chk($sformatf("vec%0d_commit_valid_drop", v), {31'b0, bus.commit_valid}, 32'h0);
      chk($sformatf("vec%0d_commit_data_hold", v), bus.commit_data, vecs[v].exp);
      $display("[TB] vec %0d: r%0d <= 0x%08h", v, vecs[v].rd, vecs[v].exp);
    end

    // Earlier writes survive later ones to other registers.
    bus.rd_addr_a = 5'd5;
    bus.rd_addr_b = 5'd13;
    #1;
    chk("r5_retained", bus.rd_data_a, 32'h12345678);
    chk("r13_retained", bus.rd_data_b, 32'hFFFF80FF);
    tick();

    // ---------------- write to register 0 ----------------
    drive(1'b1, 5'd0, 1'b0, 2'b10, 1'b0, 32'h0, 32'hDEADBEEF);
    bus.rd_addr_b = 5'd0;
    #1;
    chk("r0_same_cycle", bus.rd_data_b, 32'h0);
    tick();
    idle();
    #1;
    chk("r0_next_cycle", bus.rd_data_b, 32'h0);
    chk("r0_commit_valid", {31'b0, bus.commit_valid}, 32'h0);
    chk("r0_commit_data_hold", bus.commit_data, 32'h00000081);
    tick();
    $display("[TB] write r0 <= 0xdeadbeef discarded");

    // ---------------- bubble to r7 ----------------
    drive(1'b0, 5'd7, 1'b0, 2'b10, 1'b0, 32'h0, 32'h00000077);
    bus.rd_addr_a = 5'd7;
    #1;
    chk("bubble_no_bypass", bus.rd_data_a, 32'h0);
    tick();
    idle();
    #1;
    chk("bubble_r7", bus.rd_data_a, 32'h0);
    chk("bubble_commit_valid", {31'b0, bus.commit_valid}, 32'h0);
    tick();
    $display("[TB] bubble to r7 suppressed");

    // ---------------- back-to-back r7 = 1, r7 = 2 ----------------
    drive(1'b1, 5'd7, 1'b0, 2'b10, 1'b0, 32'h0, 32'h00000001);
    tick();
    drive(1'b1, 5'd7, 1'b0, 2'b10, 1'b0, 32'h0, 32'h00000002);
    #1;
    chk("b2b_commit1_valid", {31'b0, bus.commit_valid}, 32'h1);
    chk("b2b_commit1_reg", {27'b0, bus.commit_reg}, 32'd7);
    chk("b2b_commit1_data", bus.commit_data, 32'h1);
    chk("b2b_bypass2", bus.rd_data_a, 32'h2);
    tick();
    idle();
    #1;
    chk("b2b_commit2_valid", {31'b0, bus.commit_valid}, 32'h1);
    chk("b2b_commit2_data", bus.commit_data, 32'h2);
    chk("b2b_r7_final", bus.rd_data_a, 32'h2);
    tick();
    $display("[TB] back-to-back r7 <= 1, 2");

    // ---------------- both ports bypass the same write ----------------
    drive(1'b1, 5'd25, 1'b0, 2'b10, 1'b0, 32'h0, 32'hCAFEF00D);
    bus.rd_addr_a = 5'd25;
    bus.rd_addr_b = 5'd25;
    #1;
    chk("dual_bypass_a", bus.rd_data_a, 32'hCAFEF00D);
    chk("dual_bypass_b", bus.rd_data_b, 32'hCAFEF00D);
    tick();
    idle();
    $display("[TB] dual bypass r25 <= 0xcafef00d");

    // ---------------- reset collides with a write ----------------
    reset = 1'b1;
    drive(1'b1, 5'd9, 1'b0, 2'b10, 1'b0, 32'h0, 32'hAAAA5555);
    bus.rd_addr_a = 5'd9;
    bus.rd_addr_b = 5'd5;
    #1;
    chk("rst_wr_no_bypass", bus.rd_data_a, 32'h0);
    chk("rst_rd_b_zero", bus.rd_data_b, 32'h0);
    tick();
    reset = 1'b0;
    idle();
    #1;
    chk("rst_wr_r9", bus.rd_data_a, 32'h0);
    chk("rst_wr_r5_cleared", bus.rd_data_b, 32'h0);
    chk("rst_wr_commit_valid", {31'b0, bus.commit_valid}, 32'h0);
    chk("rst_wr_commit_reg", {27'b0, bus.commit_reg}, 32'h0);
    chk("rst_wr_commit_data", bus.commit_data, 32'h0);
    tick();
    $display("[TB] reset with write r9 <= 0xaaaa5555 dropped");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
